miss_handler: RTL

Per-cache miss controller for the phased cache. On a lookup miss it reads the victim way's dirty bit from the dirty arrays, writes the dirty victim line back to memory if needed, and fetches the new line. It then issues the one-cycle `load` strobe that refills the data, tag and dirty arrays and clears the victim's dirty bit. It sits between the tag-compare phase and the per-way storage arrays, and is the only driver of memory-side traffic.

---
 rtl/miss_handler.sv | 111 +++++++++++
 1 files changed

// File: rtl/miss_handler.sv
// Miss controller for the phased cache: optional dirty-victim writeback, four-beat
// line fill, then a one-cycle load strobe that refills the storage arrays.
module miss_handler #(
  parameter int TAG_W  = 4,
  parameter int ADDR_W = TAG_W + 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              miss,
  input  logic [1:0]        index,
  input  logic [TAG_W-1:0]  tag,
  input  logic              victim_way,
  input  logic              victim_dirty,
  input  logic [TAG_W-1:0]  victim_tag,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  output logic [1:0]        line_word,
  output logic              fill_we,
  output logic              fill_way,
  output logic [1:0]        fill_index,
  output logic              load,
  output logic              stall
);

  typedef enum logic [1:0] {IDLE, WB, FILL, LOAD} state_t;

  state_t           state, state_nxt;
  logic [1:0]       word;
  logic [1:0]       index_r;
  logic [TAG_W-1:0] tag_r;
  logic [TAG_W-1:0] victim_tag_r;
  logic             victim_way_r;

  logic accept;
  logic beat_ack;

  assign accept   = (state == IDLE) && miss;
  assign beat_ack = ((state == WB) || (state == FILL)) && mem_ack;

  // NOTE: state and data registers use non-blocking assignments so every flop
  // samples the pre-edge values; reset here is synchronous, so it lives inside
  // the clocked branch rather than in the sensitivity list.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      word         <= 2'd0;
      index_r      <= 2'd0;
      tag_r        <= '0;
      victim_tag_r <= '0;
      victim_way_r <= 1'b0;
    end else if (accept) begin
      word         <= 2'd0;
      index_r      <= index;
      tag_r        <= tag;
      victim_tag_r <= victim_tag;
      victim_way_r <= victim_way;
    end else if (beat_ack) begin
      word <= word + 2'd1;
    end
  end

  // NOTE: every combinational output gets a default before the case so no
  // path leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (miss) state_nxt = victim_dirty ? WB : FILL;
      WB:   if (mem_ack && word == 2'd3) state_nxt = FILL;
      FILL: if (mem_ack && word == 2'd3) state_nxt = LOAD;
      LOAD: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    line_word = 2'd0;
    fill_we   = 1'b0;
    load      = 1'b0;
    case (state)
      WB: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = ADDR_W'({victim_tag_r, index_r, word});
        line_word = word;
      end
      FILL: begin
        mem_req   = 1'b1;
        mem_addr  = ADDR_W'({tag_r, index_r, word});
        line_word = word;
        fill_we   = mem_ack;
      end
      LOAD:    load = 1'b1;
      default: ;
    endcase
  end

  // The incoming miss only stalls once reset is released, so all outputs read 0 in reset.
  assign stall      = (state != IDLE) || (miss && !reset);
  assign fill_way   = victim_way_r;
  assign fill_index = index_r;

endmodule
